// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetches 8-bit instructions from a synchronous ROM
// and drives register-file selects, ALU op, immediate path and write enable.
module ctrl_seq #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic [7:0]        INSTR,
  output logic [PC_W-1:0]   IMEM_ADDR,
  output logic [1:0]        SEL_A,
  output logic [1:0]        SEL_B,
  output logic [1:0]        SEL_W,
  output logic              WE,
  output logic [1:0]        ALU_OP,
  output logic [DATA_W-1:0] IMM,
  output logic              IMM_SEL,
  output logic [PC_W-1:0]   PC,
  output logic              BUSY,
  output logic              HALTED
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] HALT_INSTR = 8'h80;

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [1:0]          r_sel_a;
  logic [1:0]          r_sel_b;
  logic [1:0]          r_sel_w;
  logic [1:0]          r_alu_op;
  logic [DATA_W-1:0]   r_imm;
  logic                r_imm_sel;
  logic                r_we;
  logic                r_busy;
  logic                r_halted;
  logic                w_is_halt;

  assign w_is_halt = (INSTR == HALT_INSTR);

  // The decoded-field registers double as the instruction register: they load only
  // on DECODE -> EXEC, so a HALT decode leaves the previous selects on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_sel_a   <= '0;
      r_sel_b   <= '0;
      r_sel_w   <= '0;
      r_alu_op  <= '0;
      r_imm     <= '0;
      r_imm_sel <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_is_halt) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state   <= S_EXEC;
            r_alu_op  <= INSTR[7:6];
            r_sel_w   <= INSTR[5:4];
            r_sel_a   <= INSTR[3:2];
            r_sel_b   <= INSTR[1:0];
            r_imm     <= DATA_W'(INSTR[3:0]);
            r_imm_sel <= (INSTR[7:6] == 2'b11);
          end
        end
        S_EXEC: begin
          r_state <= S_WB;
          r_we    <= 1'b1;
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_we    <= 1'b0;
          r_pc    <= r_pc + PC_W'(1);
        end
        S_HALT: begin
          if (START) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_busy   <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign IMEM_ADDR = r_pc;
  assign PC        = r_pc;
  assign SEL_A     = r_sel_a;
  assign SEL_B     = r_sel_b;
  assign SEL_W     = r_sel_w;
  assign ALU_OP    = r_alu_op;
  assign IMM       = r_imm;
  assign IMM_SEL   = r_imm_sel;
  assign WE        = r_we;
  assign BUSY      = r_busy;
  assign HALTED    = r_halted;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: instruction-level reference model, ROM and register-file emulation,
// directed program checks and randomized runs with random START and asynchronous resets.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       START = 1'b0;
  logic [7:0] INSTR = 8'h00;
  logic [3:0] IMEM_ADDR, PC, IMM;
  logic [1:0] SEL_A, SEL_B, SEL_W, ALU_OP;
  logic       WE, IMM_SEL, BUSY, HALTED;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.PC_W(4), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .START(START), .INSTR(INSTR), .IMEM_ADDR(IMEM_ADDR),
    .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_W(SEL_W), .WE(WE), .ALU_OP(ALU_OP),
    .IMM(IMM), .IMM_SEL(IMM_SEL), .PC(PC), .BUSY(BUSY), .HALTED(HALTED)
  );

  // Synchronous-read instruction ROM
  logic [7:0] rom [16];
  always @(posedge clk) INSTR <= rom[IMEM_ADDR];

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [3:0] b,
                                     input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      default: return a & b;
    endcase
  endfunction

  // Register file emulation driven by the sequencer outputs
  logic [3:0] rf [4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'h0;
    end else if (WE) begin
      rf[SEL_W] <= IMM_SEL ? IMM : alu(rf[SEL_A], rf[SEL_B], ALU_OP);
    end
  end

  // Reference model: instruction in flight plus position (0..3) inside its 4-cycle slot
  typedef struct packed {
    logic       run;
    logic       halt;
    logic [1:0] k;
    logic [3:0] pc;
    logic [1:0] sa, sb, sw, op;
    logic [3:0] imm;
    logic       isel;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(input mdl_t c, input logic st);
    mdl_t n;
    logic [7:0] ins;
    n = c;
    if (!c.run) begin
      if (st) begin
        if (c.halt) n.pc = 4'd0;
        n.halt = 1'b0;
        n.run  = 1'b1;
        n.k    = 2'd0;
      end
    end else begin
      case (c.k)
        2'd1: begin
          ins = rom[c.pc];
          if (ins == 8'h80) begin
            n.run  = 1'b0;
            n.halt = 1'b1;
          end else begin
            n.op   = ins[7:6];
            n.sw   = ins[5:4];
            n.sa   = ins[3:2];
            n.sb   = ins[1:0];
            n.imm  = ins[3:0];
            n.isel = (ins[7:6] == 2'b11);
            n.k    = 2'd2;
          end
        end
        2'd3: begin
          n.pc = (c.pc + 4'd1) % 16;
          n.k  = 2'd0;
        end
        default: n.k = c.k + 2'd1;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= mdl_next(m, START);
  end

  function automatic logic [23:0] exp_vec(input mdl_t c);
    return {c.pc, c.sa, c.sb, c.sw, (c.run && c.k == 2'd3), c.op, c.imm, c.isel,
            c.pc, c.run, c.halt};
  endfunction

  logic [23:0] w_dut_vec;
  assign w_dut_vec = {IMEM_ADDR, SEL_A, SEL_B, SEL_W, WE, ALU_OP, IMM, IMM_SEL,
                      PC, BUSY, HALTED};

  always @(negedge clk) begin
    checks++;
    if (w_dut_vec !== exp_vec(m)) begin
      fails++;
      $display("FAIL cycle_model t=%0t: got %06h expected %06h", $time, w_dut_vec, exp_vec(m));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  logic [31:0] wv, hv;
  logic [1:0]  swv [17];
  logic        busy_all;
  logic        found;
  int          we_cnt;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {8'h0, w_dut_vec}, 32'h0);

    // LDI r1,3; LDI r2,5; ADD r3,r1,r2; HALT
    rom[0] = 8'hD3; rom[1] = 8'hE5; rom[2] = 8'h36; rom[3] = 8'h80;
    rst = 1'b0;
    @(negedge clk);
    START = 1'b1;
    wv = '0; hv = '0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (n == 1) START = 1'b0;
      wv[n]  = WE;
      hv[n]  = HALTED;
      swv[n] = SEL_W;
    end
    chk("we_pulse_cycles", wv, 32'h0000_1110);
    chk("halted_from_cycle15", hv, 32'h0001_8000);
    chk("selw_c4", {30'h0, swv[4]}, 32'd1);
    chk("selw_c8", {30'h0, swv[8]}, 32'd2);
    chk("selw_c12", {30'h0, swv[12]}, 32'd3);
    chk("prog1_pc", {28'h0, PC}, 32'd3);
    chk("prog1_r1", {28'h0, rf[1]}, 32'd3);
    chk("prog1_r2", {28'h0, rf[2]}, 32'd5);
    chk("prog1_r3", {28'h0, rf[3]}, 32'd8);

    // Restart from HALT: LDI r1,2; LDI r2,5; SUB r0,r1,r2; HALT
    rom[0] = 8'hD2; rom[1] = 8'hE5; rom[2] = 8'h46; rom[3] = 8'h80;
    @(negedge clk);
    START = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        START = 1'b0;
        chk("restart_pc", {28'h0, PC}, 32'd0);
        chk("restart_flags", {30'h0, BUSY, HALTED}, 32'h2);
        chk("restart_addr", {28'h0, IMEM_ADDR}, 32'd0);
      end
      if (n == 11 || n == 12)
        chk("sub_ctrl", {25'h0, ALU_OP, SEL_A, SEL_B, WE}, {25'h0, 2'b01, 2'd1, 2'd2, (n == 12)});
    end
    chk("sub_wrap_r0", {28'h0, rf[0]}, 32'hD);

    // 16 non-HALT instructions with START held high: PC wraps, no restart
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'($urandom_range(0, 255));
      if (rom[i] == 8'h80) rom[i] = 8'h81;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    START = 1'b1;
    busy_all = 1'b1;
    for (int n = 1; n <= 66; n++) begin
      @(posedge clk); #1;
      busy_all = busy_all & BUSY;
      if (n == 5)  chk("held_start_pc", {28'h0, PC}, 32'd1);
      if (n == 61) chk("pc_15", {28'h0, PC}, 32'd15);
      if (n == 65) chk("pc_wrap", {26'h0, PC, BUSY, IMEM_ADDR == 4'd0}, {26'h0, 4'd0, 1'b1, 1'b1});
    end
    chk("busy_through_wrap", {31'h0, busy_all}, 32'd1);
    START = 1'b0;

    // Asynchronous reset during WB
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(negedge clk);
      if (WE) found = 1'b1;
    end
    chk("wb_reached", {31'h0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset_mid_wb_we", {31'h0, WE}, 32'd0);
    chk("reset_mid_wb_state", {8'h0, w_dut_vec}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    we_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (WE) we_cnt++;
    end
    chk("no_write_after_reset", we_cnt, 32'd0);

    // Randomized programs, START activity and occasional asynchronous resets
    for (int r = 0; r < 6; r++) begin
      rst = 1'b1;
      for (int i = 0; i < 16; i++)
        rom[i] = ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 150; n++) begin
        @(negedge clk);
        START = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) == 0) begin
          #2 rst = 1'b1;
          #4 rst = 1'b0;
        end
      end
      START = 1'b0;
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
